// File: rtl/seq_comparator_pkg.sv
// seq_comparator_pkg: funct3 compare op codes and scan FSM state encoding
package seq_comparator_pkg;
  localparam logic [3:0] OP_EQ  = 4'd0;
  localparam logic [3:0] OP_NE  = 4'd1;
  localparam logic [3:0] OP_LT  = 4'd4;
  localparam logic [3:0] OP_GE  = 4'd5;
  localparam logic [3:0] OP_LTU = 4'd6;
  localparam logic [3:0] OP_GEU = 4'd7;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic logic op_valid(input logic [3:0] op);
    return op inside {OP_EQ, OP_NE, OP_LT, OP_GE, OP_LTU, OP_GEU};
  endfunction
endpackage

// File: rtl/seq_comparator_chunk_compare.sv
// chunk_compare: unsigned eq/lt of one chunk, optional MSB flip for signed top chunk
module chunk_compare #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             invert_msb,
  output logic             eq,
  output logic             lt
);
  logic [CHUNK-1:0] flip;
  assign flip = CHUNK'(invert_msb) << (CHUNK - 1);
  assign eq = a == b;
  assign lt = (a ^ flip) < (b ^ flip);
endmodule

// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle MSB-first chunked funct3 comparator with valid/ready handshakes
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  state_t state, state_n;
  logic [WIDTH-1:0] xr, yr;
  logic [3:0] op;
  logic [KW-1:0] k;
  logic [CHUNK-1:0] xc, yc;
  logic eq, lt, top, last, res, accept;
  assign xc = xr[k*CHUNK +: CHUNK];
  assign yc = yr[k*CHUNK +: CHUNK];
  assign top = k == KW'(N - 1);
  chunk_compare #(.CHUNK(CHUNK)) u_cmp (
    .a(xc),
    .b(yc),
    .invert_msb(top && (op == OP_LT || op == OP_GE)),
    .eq(eq),
    .lt(lt)
  );
  assign last = !eq || k == '0 || !op_valid(op);
  assign res = (op == OP_EQ) ? eq && k == '0 :
               (op == OP_NE) ? !eq :
               (op == OP_LT || op == OP_LTU) ? lt :
               (op == OP_GE || op == OP_GEU) ? !lt : 1'b0;
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && in_valid) state_n = SCAN;
    else if (state == SCAN && last) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  always_comb begin
    in_ready  = state == IDLE && !reset;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) O <= '0;
    else if (state == SCAN && last) O <= WIDTH'(res);
    if (accept) begin
      xr <= X;
      yr <= Y;
      op <= operation;
      k  <= KW'(N - 1);
    end else if (state == SCAN && !last) k <= k - 1'b1;
  end
endmodule

// File: tb/tb_seq_comparator.sv
// tb_seq_comparator: directed and randomized checks of seq_comparator against an arithmetic model
module tb_seq_comparator;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [3:0] operation = 0;
  logic [31:0] X = 0, Y = 0;
  logic in_ready, out_valid;
  logic [31:0] O;
  int checks = 0, errors = 0;

  seq_comparator #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .X(X), .Y(Y), .out_valid(out_valid),
    .out_ready(out_ready), .O(O)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output int lat);
    bit found = 0;
    lat = 4;
    for (int i = 3; i >= 0; i--)
      if (!found && x[i*8 +: 8] != y[i*8 +: 8]) begin
        found = 1;
        lat = 4 - i;
      end
    case (op)
      4'd0: r = 32'(x == y);
      4'd1: r = 32'(x != y);
      4'd4: r = 32'($signed(x) < $signed(y));
      4'd5: r = 32'($signed(x) >= $signed(y));
      4'd6: r = 32'(x < y);
      4'd7: r = 32'(x >= y);
      default: begin r = 0; lat = 1; end
    endcase
  endfunction

  // Issues one request from an idle DUT, measures edges to out_valid, then consumes the result.
  task automatic do_req(input logic [3:0] op_i, input logic [31:0] x_i, input logic [31:0] y_i,
                        input bit hold, output logic [31:0] o_got, output int lat);
    in_valid = 1; operation = op_i; X = x_i; Y = y_i; out_ready = hold;
    @(posedge clk); #1;
    in_valid = 0; operation = 4'($urandom); X = $urandom; Y = $urandom;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 20);
    o_got = O;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic directed(input string name, input logic [3:0] op_i, input logic [31:0] x_i,
                          input logic [31:0] y_i, input logic [31:0] exp_o, input int exp_lat);
    logic [31:0] o_got;
    int lat;
    do_req(op_i, x_i, y_i, 0, o_got, lat);
    checks += 2;
    if (o_got !== exp_o) begin errors++; $display("FAIL %s result: got %0h expected %0h", name, o_got, exp_o); end
    if (lat !== exp_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat); end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    if (O !== 32'h0) begin errors++; $display("FAIL reset O: got %0h expected 0", O); end
    reset = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post-reset in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    directed("ltu_lsb", 4'd6, 32'h1, 32'h2, 32'h1, 4);
    directed("lt_signed_msb", 4'd4, 32'hFFFFFFFF, 32'h1, 32'h1, 1);
    directed("ltu_msb", 4'd6, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
    directed("eq_equal", 4'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h1, 4);
    directed("ne_equal", 4'd1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 4);
    directed("eq_lsb_diff", 4'd0, 32'hDEADBEEF, 32'hDEADBEEE, 32'h0, 4);
    directed("ge_signed_equal", 4'd5, 32'h80000000, 32'h80000000, 32'h1, 4);
    directed("ge_signed_msb", 4'd5, 32'h7FFFFFFF, 32'h80000000, 32'h1, 1);
    directed("geu_msb", 4'd7, 32'h7FFFFFFF, 32'h80000000, 32'h0, 1);
  endtask

  task automatic test_backpressure();
    int lat = 0;
    in_valid = 1; operation = 4'd2; X = 32'h12345678; Y = 32'h12345678; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 20);
    checks += 2;
    if (lat !== 1) begin errors++; $display("FAIL invalid_op latency: got %0d expected 1", lat); end
    if (O !== 32'h0) begin errors++; $display("FAIL invalid_op result: got %0h expected 0", O); end
    in_valid = 1; operation = 4'd0; X = 32'h5; Y = 32'h5;
    repeat (3) begin
      @(posedge clk); #1;
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall out_valid: got %b expected 1", out_valid); end
      if (O !== 32'h0) begin errors++; $display("FAIL stall O: got %0h expected 0", O); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall in_ready: got %b expected 0", in_ready); end
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL release out_valid: got %b expected 0", out_valid); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ignored request out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_scan();
    in_valid = 1; operation = 4'd0; X = 32'hCAFEF00D; Y = 32'hCAFEF00D; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL scan in_ready: got %b expected 0", in_ready); end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    #1;
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort in_ready: got %b expected 1", in_ready); end
    if (O !== 32'h0) begin errors++; $display("FAIL abort O: got %0h expected 0", O); end
    repeat (6) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL abort out_valid: got %b expected 0", out_valid); end
    end
    out_ready = 0;
    directed("geu_after_reset", 4'd7, 32'h5, 32'h3, 32'h1, 4);
  endtask

  task automatic test_random();
    logic [3:0] ops [6] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7};
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op_i;
      logic [31:0] x, y, o_got, exp_o;
      int lat, exp_lat;
      op_i = ($urandom_range(0, 4) == 0) ? 4'($urandom) : ops[$urandom_range(0, 5)];
      x = $urandom;
      y = x;
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 3) == 0) y[c*8 +: 8] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) y[31] = ~y[31];
      model(op_i, x, y, exp_o, exp_lat);
      do_req(op_i, x, y, n[0], o_got, lat);
      checks += 2;
      if (o_got !== exp_o) begin errors++; $display("FAIL random op=%0d x=%h y=%h result: got %0h expected %0h", op_i, x, y, o_got, exp_o); end
      if (lat !== exp_lat) begin errors++; $display("FAIL random op=%0d x=%h y=%h latency: got %0d expected %0d", op_i, x, y, lat, exp_lat); end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      logic [31:0] x, y, o_got, exp_o;
      int lat, exp_lat;
      x = $urandom;
      y = (n % 2 == 0) ? x : $urandom;
      model(4'd6, x, y, exp_o, exp_lat);
      do_req(4'd6, x, y, 1, o_got, lat);
      checks += 4;
      if (o_got !== exp_o) begin errors++; $display("FAIL b2b result: got %0h expected %0h", o_got, exp_o); end
      if (lat !== exp_lat) begin errors++; $display("FAIL b2b latency: got %0d expected %0d", lat, exp_lat); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b in_ready: got %b expected 1", in_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b out_valid: got %b expected 0", out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_comparator.md
# seq_comparator

Parametrised, multi-cycle successor to the CPU's single-cycle comparator. Evaluates the same six RISC-V funct3 compare operations over a WIDTH-bit operand pair, scanning CHUNK bits per cycle from MSB to LSB. The scan terminates early at the first differing chunk. Sits beside the ALU in area-constrained builds and uses valid/ready handshakes on both sides, so the control FSM can stall on it.

## Interface
- WIDTH, 32: operand and result width. Must be a multiple of CHUNK.
- CHUNK, 8: bits compared per cycle. N = WIDTH/CHUNK chunks, N ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- operation  in  4  funct3 code: 0 EQ, 1 NE, 4 LT signed, 5 GE signed, 6 LT unsigned, 7 GE unsigned.
- X  in  WIDTH  left operand.
- Y  in  WIDTH  right operand.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- O  out  WIDTH  result: bit 0 = compare outcome, bits WIDTH-1:1 = 0.

## Operation
- States:
  - IDLE: in_ready=1.
  - SCAN: index k counts chunks from MSB.
  - DONE: out_valid=1.
- Accept happens when in_valid && in_ready at a clock edge. On accept, latch X, Y and operation, set k=N-1, and go to SCAN. Live inputs are ignored after accept.
- Chunk compare in SCAN:
  - Compare chunk k of the latched operands unsigned, producing eq and lt.
  - For signed ops, chunk N-1 has its top bit inverted in both operands before the compare (two's-complement to offset-binary). Lower chunks are always unsigned.
- SCAN exit: if the chunk is not equal, or k==0, or the operation is invalid, register the result into O and go to DONE. Otherwise decrement k and stay in SCAN.
- Result, where lt/eq come from the deciding chunk and all higher chunks are equal:
  - EQ: eq && (k==0).
  - NE: !eq.
  - LT/LTU: lt.
  - GE/GEU: !lt.
  - Invalid codes (2, 3, 8–15): 0.
- DONE: hold O and out_valid until out_valid && out_ready, then return to IDLE.
- No overlap: in_ready=0 in SCAN and DONE.
- O is only updated on the SCAN→DONE transition and is otherwise stable.

## Timing
- Reset values: state IDLE, O=0, out_valid=0. in_ready=0 while reset is high, and 1 in the cycle after reset deasserts.
- Reset mid-SCAN or mid-DONE aborts the request. No result is emitted.
- Latency from accept edge to out_valid high equals the number of chunks examined, 1..N edges.
  - Differing MSB chunk: 1.
  - Operands equal: N.
  - Invalid op: 1.
- Handshake:
  - out_valid && out_ready at edge E: in_ready is high in the cycle after E; next accept is possible at E+1.
  - Minimum request-to-request spacing is latency + 1 edges.
  - out_ready held high at DONE entry: the result is consumed at the first edge where out_valid is seen.
- N=1 (CHUNK=WIDTH): every op has latency 1.

## Structure
- Shared package/header holds:
  - the funct3 comparator op constants, the same values the single-cycle comparator uses;
  - the state encoding IDLE/SCAN/DONE.
- One combinational sub-module, `chunk_compare` (CHUNK-wide, with an invert_msb input), producing eq and lt.
- The top level contains the FSM, operand registers, chunk mux and result register.

## Test plan
All cases use WIDTH=32, CHUNK=8.
- **LTU, LSB difference:** op=6, X=0x00000001, Y=0x00000002 → O=1, out_valid 4 edges after accept.
- **Signed vs unsigned, MSB difference:** X=0xFFFFFFFF, Y=0x00000001 → op=4 gives O=1, op=6 gives O=0; latency 1 each.
- **EQ/NE on equal operands:** X=Y=0xDEADBEEF → op=0 gives O=1, op=1 gives O=0; latency 4. Then X=0xDEADBEEF, Y=0xDEADBEEE, op=0 → O=0, latency 4.
- **GE signed, equal operands:** op=5, X=Y=0x80000000 → O=1, latency 4. Then op=5, X=0x7FFFFFFF, Y=0x80000000 → O=1, latency 1.
- **Backpressure and invalid op:** op=2 → O=0, latency 1. Hold out_ready=0 for 3 cycles → O and out_valid stable, in_ready=0, a new in_valid is ignored. After release, in_ready=1 the next cycle.
- **Reset mid-scan:** assert reset for 1 cycle during SCAN of an equal-operand op=0 request → out_valid stays 0, O=0, in_ready=1 after reset. A following op=7, X=5, Y=3 → O=1.
